// File: rtl/mlp_dot_sequencer.sv
// Operand sequencer for the MLP MAC: walks one input vector and one weight row from
// 1-cycle-latency RAMs, strobes the MAC, and captures the finished dot product.
module mlp_dot_sequencer #(
  parameter int A_WIDTH    = 16,
  parameter int B_WIDTH    = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int ROW_WIDTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                go,
  input  logic        [ADDR_WIDTH:0]          len,
  input  logic        [ROW_WIDTH-1:0]         row,
  output logic                                busy,
  output logic                                rd_en,
  output logic        [ADDR_WIDTH-1:0]        x_addr,
  output logic        [ROW_WIDTH+ADDR_WIDTH-1:0] w_addr,
  input  logic signed [A_WIDTH-1:0]           x_rdata,
  input  logic signed [B_WIDTH-1:0]           w_rdata,
  output logic signed [A_WIDTH-1:0]           mac_a,
  output logic signed [B_WIDTH-1:0]           mac_b,
  output logic                                mac_start,
  output logic                                mac_valid,
  input  logic signed [ACC_WIDTH-1:0]         mac_result,
  output logic signed [ACC_WIDTH-1:0]         dot_out,
  output logic                                dot_valid
);

  localparam logic [ADDR_WIDTH:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    LAST   = 3'd2,
    CAPT   = 3'd3,
    CAPT_Z = 3'd4
  } state_t;

  state_t                         state_q;
  logic        [ADDR_WIDTH-1:0]   idx_q;
  logic        [ADDR_WIDTH:0]     len_q;
  logic        [ROW_WIDTH-1:0]    row_q;
  logic                           busy_q;
  logic                           rd_en_q;
  logic                           pend_q;
  logic                           first_q;
  logic signed [ACC_WIDTH-1:0]    dot_q;
  logic                           dot_valid_q;

  logic        [ADDR_WIDTH:0]     len_d;
  logic                           last_d;

  assign len_d  = (len > LEN_MAX) ? LEN_MAX : len;
  assign last_d = ({1'b0, idx_q} == (len_q - (ADDR_WIDTH+1)'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      row_q       <= '0;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      pend_q      <= 1'b0;
      first_q     <= 1'b0;
      dot_q       <= '0;
      dot_valid_q <= 1'b0;
    end else begin
      // RAM data lands one cycle after the read, so the MAC strobes trail rd_en by one
      pend_q      <= rd_en_q;
      first_q     <= rd_en_q && (idx_q == '0);
      dot_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go) begin
            len_q  <= len_d;
            row_q  <= row;
            idx_q  <= '0;
            busy_q <= 1'b1;
            if (len_d == '0) begin
              state_q <= CAPT_Z;
            end else begin
              state_q <= RUN;
              rd_en_q <= 1'b1;
            end
          end
        end
        RUN: begin
          // idx holds on the final read so it never wraps past LEN_MAX-1
          if (last_d) begin
            rd_en_q <= 1'b0;
            state_q <= LAST;
          end else begin
            idx_q <= idx_q + ADDR_WIDTH'(1);
          end
        end
        LAST: begin
          state_q <= CAPT;
        end
        CAPT: begin
          dot_q       <= mac_result;
          dot_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        CAPT_Z: begin
          dot_q       <= '0;
          dot_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          rd_en_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign rd_en     = rd_en_q;
  assign x_addr    = idx_q;
  assign w_addr    = {row_q, idx_q};
  assign mac_a     = pend_q ? x_rdata : '0;
  assign mac_b     = pend_q ? w_rdata : '0;
  assign mac_start = pend_q & first_q;
  assign mac_valid = pend_q & ~first_q;
  assign dot_out   = dot_q;
  assign dot_valid = dot_valid_q;

endmodule

// File: tb/tb_mlp_dot_sequencer.sv
// Bench for mlp_dot_sequencer: behavioural RAMs and MAC around the DUT, expected dot
// products queued at go and compared when dot_valid appears.
module tb_mlp_dot_sequencer;

  logic               clk;
  logic               rst;
  logic               go;
  logic [6:0]         len;
  logic [3:0]         row;
  logic               busy;
  logic               rd_en;
  logic [5:0]         x_addr;
  logic [9:0]         w_addr;
  logic signed [15:0] x_rdata;
  logic signed [15:0] w_rdata;
  logic signed [15:0] mac_a;
  logic signed [15:0] mac_b;
  logic               mac_start;
  logic               mac_valid;
  logic signed [31:0] mac_result;
  logic signed [31:0] dot_out;
  logic               dot_valid;

  mlp_dot_sequencer dut (
    .clk(clk), .rst(rst), .go(go), .len(len), .row(row),
    .busy(busy), .rd_en(rd_en), .x_addr(x_addr), .w_addr(w_addr),
    .x_rdata(x_rdata), .w_rdata(w_rdata),
    .mac_a(mac_a), .mac_b(mac_b), .mac_start(mac_start), .mac_valid(mac_valid),
    .mac_result(mac_result), .dot_out(dot_out), .dot_valid(dot_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] x_mem [64];
  logic signed [15:0] w_mem [1024];

  always @(posedge clk) begin
    if (rd_en) begin
      x_rdata <= x_mem[x_addr];
      w_rdata <= w_mem[w_addr];
    end
  end

  // MAC has no reset: only mac_start clears its accumulator
  logic signed [31:0] acc;
  logic signed [31:0] a32, b32;
  assign a32 = 32'(mac_a);
  assign b32 = 32'(mac_b);
  assign mac_result = acc;
  always @(posedge clk) begin
    if (mac_start)      acc <= a32 * b32;
    else if (mac_valid) acc <= acc + a32 * b32;
  end

  int       cyc, n_rd, n_start, n_valid, n_both, n_dv, dv_cyc;
  logic [5:0] last_xa;
  logic [9:0] wa_log [3];

  always @(posedge clk or negedge clk) begin
    if (clk) begin
      if (go && !busy && !rst) begin
        cyc <= 1; n_rd <= 0; n_start <= 0; n_valid <= 0; n_both <= 0; n_dv <= 0; dv_cyc <= 0;
      end else begin
        cyc <= cyc + 1;
      end
    end else begin
      if (rd_en) begin
        n_rd    <= n_rd + 1;
        last_xa <= x_addr;
        if (n_rd < 3) wa_log[n_rd] <= w_addr;
      end
      if (mac_start) n_start <= n_start + 1;
      if (mac_valid) n_valid <= n_valid + 1;
      if (mac_start && mac_valid) n_both <= n_both + 1;
      if (dot_valid) begin
        n_dv   <= n_dv + 1;
        dv_cyc <= cyc;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  logic signed [31:0] exp_q [$];
  logic signed [31:0] exp_v;

  function automatic logic signed [31:0] dot_model(input int l, input int r);
    logic signed [31:0] s;
    int n;
    s = '0;
    n = (l > 64) ? 64 : l;
    for (int i = 0; i < n; i++) s = s + 32'(x_mem[i]) * 32'(w_mem[r*64 + i]);
    return s;
  endfunction

  // Called at negedge+1 with busy low; returns in cycle 1 of the accepted operation
  task automatic start_op(input int l, input int r, input bit push);
    go = 1'b1; len = 7'(l); row = 4'(r);
    @(negedge clk); #1;
    go = 1'b0;
    if (push) exp_q.push_back(dot_model(l, r));
  endtask

  task automatic wait_dv(input int limit, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < limit && !seen; k++) begin
      if (dot_valid) seen = 1'b1;
      else begin @(negedge clk); #1; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; go = 1'b0; len = '0; row = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy, rd_en, mac_start, mac_valid, dot_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {busy, rd_en, mac_start, mac_valid, dot_valid});
    end
    checks++;
    if (dot_out !== 32'sd0) begin errors++; $display("FAIL reset_dot: got %0d want 0", dot_out); end
    checks++;
    if ({x_addr, w_addr, mac_a, mac_b} !== '0) begin
      errors++; $display("FAIL reset_addr: x_addr=%0d w_addr=%0d mac_a=%0d mac_b=%0d want all 0", x_addr, w_addr, mac_a, mac_b);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic;
    int xs[3] = '{1, 2, 3};
    int ws[3] = '{4, 5, 6};
    bit seen;
    for (int i = 0; i < 3; i++) begin x_mem[i] = 16'(xs[i]); w_mem[2*64 + i] = 16'(ws[i]); end
    start_op(3, 2, 1'b1);
    wait_dv(12, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL basic_timeout: dot_valid got none want one within 12 cycles"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++;
      if (dot_out !== exp_v || dot_out !== 32'sd32) begin errors++; $display("FAIL basic_dot: got %0d want %0d", dot_out, exp_v); end
      checks++;
      if (dv_cyc !== 6) begin errors++; $display("FAIL basic_latency: got %0d want 6", dv_cyc); end
      checks++;
      if ({wa_log[0], wa_log[1], wa_log[2]} !== {10'h080, 10'h081, 10'h082}) begin
        errors++; $display("FAIL basic_waddr: got %h %h %h want 080 081 082", wa_log[0], wa_log[1], wa_log[2]);
      end
      checks++;
      if (n_rd !== 3 || n_start !== 1 || n_valid !== 2) begin
        errors++; $display("FAIL basic_strobes: rd=%0d start=%0d valid=%0d want 3 1 2", n_rd, n_start, n_valid);
      end
    end
  endtask

  task automatic test_signed;
    int xs[4] = '{-2, 7, -32768, 0};
    int ws[4] = '{3, -1, 1, 5};
    bit seen;
    for (int i = 0; i < 4; i++) begin x_mem[i] = 16'(xs[i]); w_mem[5*64 + i] = 16'(ws[i]); end
    start_op(4, 5, 1'b1);
    wait_dv(14, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL signed_timeout: dot_valid got none want one within 14 cycles"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++;
      if (dot_out !== exp_v || dot_out !== 32'hFFFF7FF3) begin errors++; $display("FAIL signed_dot: got %h want %h", dot_out, exp_v); end
      checks++;
      if (n_start !== 1 || n_valid !== 3 || n_both !== 0) begin
        errors++; $display("FAIL signed_strobes: start=%0d valid=%0d both=%0d want 1 3 0", n_start, n_valid, n_both);
      end
    end
    for (int i = 0; i < 2; i++) begin x_mem[i] = -16'sd32768; w_mem[i] = -16'sd32768; end
    start_op(2, 0, 1'b1);
    wait_dv(12, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL wrap_timeout: dot_valid got none want one within 12 cycles"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++;
      if (dot_out !== exp_v || dot_out !== 32'h80000000) begin errors++; $display("FAIL wrap_dot: got %h want %h", dot_out, exp_v); end
    end
  endtask

  task automatic test_len_bounds;
    bit seen;
    start_op(0, 1, 1'b1);
    wait_dv(6, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL len0_timeout: dot_valid got none want one within 6 cycles"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++;
      if (dot_out !== exp_v || dot_out !== 32'sd0) begin errors++; $display("FAIL len0_dot: got %0d want 0", dot_out); end
      checks++;
      if (dv_cyc !== 2) begin errors++; $display("FAIL len0_latency: got %0d want 2", dv_cyc); end
      checks++;
      if (n_rd !== 0 || n_start !== 0 || n_valid !== 0) begin
        errors++; $display("FAIL len0_strobes: rd=%0d start=%0d valid=%0d want 0 0 0", n_rd, n_start, n_valid);
      end
    end
    for (int i = 0; i < 64; i++) begin
      x_mem[i] = 16'($urandom);
      w_mem[7*64 + i] = 16'($urandom);
    end
    start_op(80, 7, 1'b1);
    wait_dv(80, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL clamp_timeout: dot_valid got none want one within 80 cycles"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++;
      if (dot_out !== exp_v) begin errors++; $display("FAIL clamp_dot: got %h want %h", dot_out, exp_v); end
      checks++;
      if (n_rd !== 64 || last_xa !== 6'd63) begin errors++; $display("FAIL clamp_reads: rd=%0d last_x=%0d want 64 63", n_rd, last_xa); end
      checks++;
      if (dv_cyc !== 67) begin errors++; $display("FAIL clamp_latency: got %0d want 67", dv_cyc); end
    end
  endtask

  task automatic test_back_to_back;
    bit seen;
    logic signed [31:0] prev;
    for (int i = 0; i < 3; i++) begin x_mem[i] = 16'sd1; w_mem[3*64 + i] = 16'sd2; end
    start_op(3, 3, 1'b1);
    go = 1'b1; len = 7'd1; row = 4'd0;
    repeat (3) begin @(negedge clk); #1; end
    go = 1'b0;
    wait_dv(12, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL busygo_timeout: dot_valid got none want one within 12 cycles"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++;
      if (dot_out !== exp_v || dot_out !== 32'sd6) begin errors++; $display("FAIL busygo_dot: got %0d want %0d", dot_out, exp_v); end
      checks++;
      if (dv_cyc !== 6 || n_rd !== 3 || n_dv !== 1) begin
        errors++; $display("FAIL busygo_ignored: dv_cyc=%0d rd=%0d dv=%0d want 6 3 1", dv_cyc, n_rd, n_dv);
      end
    end
    prev = dot_out;
    x_mem[0] = 16'sd9; w_mem[4*64] = 16'sd9;
    start_op(1, 4, 1'b1);
    checks++;
    if (dot_out !== prev || dot_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_hold: dot_out=%0d dot_valid=%b want %0d 0", dot_out, dot_valid, prev);
    end
    wait_dv(8, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL b2b_timeout: dot_valid got none want one within 8 cycles"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++;
      if (dot_out !== exp_v || dot_out !== 32'sd81) begin errors++; $display("FAIL b2b_dot: got %0d want %0d", dot_out, exp_v); end
      checks++;
      if (dv_cyc !== 4) begin errors++; $display("FAIL b2b_latency: got %0d want 4", dv_cyc); end
    end
  endtask

  task automatic test_abort;
    bit seen;
    int dv_seen;
    for (int i = 0; i < 5; i++) begin x_mem[i] = 16'(i + 3); w_mem[1*64 + i] = 16'(i + 11); end
    start_op(5, 1, 1'b0);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, rd_en, mac_start, mac_valid, dot_valid} !== 5'b0 || dot_out !== 32'sd0) begin
      errors++; $display("FAIL abort_async: ctrl=%b dot_out=%0d want 00000 0", {busy, rd_en, mac_start, mac_valid, dot_valid}, dot_out);
    end
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    dv_seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (dot_valid || busy) dv_seen++;
      @(negedge clk); #1;
    end
    checks++;
    if (dv_seen !== 0) begin errors++; $display("FAIL abort_no_dv: got %0d active cycles want 0", dv_seen); end
    for (int i = 0; i < 3; i++) begin x_mem[i] = 16'(i + 1); w_mem[2*64 + i] = 16'(i + 4); end
    start_op(3, 2, 1'b1);
    wait_dv(12, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL rerun_timeout: dot_valid got none want one within 12 cycles"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++;
      if (dot_out !== exp_v || dot_out !== 32'sd32) begin errors++; $display("FAIL rerun_dot: got %0d want %0d", dot_out, exp_v); end
    end
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; len = '0; row = '0;
    for (int i = 0; i < 64; i++) x_mem[i] = '0;
    for (int i = 0; i < 1024; i++) w_mem[i] = '0;
    test_reset();
    test_basic();
    test_signed();
    test_len_bounds();
    test_back_to_back();
    test_abort();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
